// File: rtl/rca_error_sweep_ctrl_if.sv
// Bundle between the sweep controller and its host/adder-under-test side.
// The host drives start/abort and returns dut_S; the controller owns everything else.
interface rca_error_sweep_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 abort;
    logic [WIDTH-1:0]     dut_A;
    logic [WIDTH-1:0]     dut_B;
    logic                 dut_Cin;
    logic [WIDTH:0]       dut_S;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH+1:0]   err_count;
    logic [WIDTH:0]       max_ed;
    logic [3*WIDTH+1:0]   sum_ed;
    logic [2*WIDTH+1:0]   vec_count;

    modport master (
        output start, abort, dut_S,
        input  dut_A, dut_B, dut_Cin, busy, done, err_count, max_ed, sum_ed, vec_count
    );

    modport slave (
        input  start, abort, dut_S,
        output dut_A, dut_B, dut_Cin, busy, done, err_count, max_ed, sum_ed, vec_count
    );
endinterface

// File: rtl/rca_error_sweep_ctrl.sv
// Exhaustive operand sweep of an approximate adder, accumulating error count,
// maximum and summed error distance against the exact sum.
module rca_error_sweep_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    rca_error_sweep_ctrl_if.slave     bus
);
    localparam int IW    = 2*WIDTH + 1;
    localparam int CW    = 2*WIDTH + 2;
    localparam int ACC_W = 3*WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state, state_next;
    logic [IW-1:0]    idx;
    logic [WIDTH:0]   stage_exact;
    logic [WIDTH:0]   stage_s;
    logic             stage_valid;
    logic             done_q;
    logic [CW-1:0]    err_count_q;
    logic [WIDTH:0]   max_ed_q;
    logic [ACC_W-1:0] sum_ed_q;
    logic [CW-1:0]    vec_count_q;

    logic             load;
    logic             capture;
    logic             finish;
    logic             idx_last;
    logic [WIDTH:0]   exact;
    logic [WIDTH:0]   ed;

    assign idx_last = (idx == {IW{1'b1}});
    assign exact    = {1'b0, idx[WIDTH-1:0]} + {1'b0, idx[2*WIDTH-1:WIDTH]}
                    + {{WIDTH{1'b0}}, idx[2*WIDTH]};
    assign ed       = (stage_exact >= stage_s) ? (stage_exact - stage_s)
                                               : (stage_s - stage_exact);

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else begin
                    capture = 1'b1;
                    if (idx_last) state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = IDLE;
                finish     = !bus.abort;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; all registers are small and cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            stage_exact <= '0;
            stage_s     <= '0;
            stage_valid <= 1'b0;
            done_q      <= 1'b0;
            err_count_q <= '0;
            max_ed_q    <= '0;
            sum_ed_q    <= '0;
            vec_count_q <= '0;
        end else begin
            state  <= state_next;
            done_q <= finish;
            if (load) begin
                idx         <= '0;
                stage_valid <= 1'b0;
                err_count_q <= '0;
                max_ed_q    <= '0;
                sum_ed_q    <= '0;
                vec_count_q <= '0;
            end else begin
                // Accumulate the vector captured on the previous edge.
                if (stage_valid) begin
                    vec_count_q <= vec_count_q + 1'b1;
                    if (ed != '0) err_count_q <= err_count_q + 1'b1;
                    sum_ed_q <= sum_ed_q + ACC_W'(ed);
                    if (ed > max_ed_q) max_ed_q <= ed;
                end
                stage_valid <= capture;
                if (capture) begin
                    stage_exact <= exact;
                    stage_s     <= bus.dut_S;
                    if (!idx_last) idx <= idx + 1'b1;
                end
            end
        end
    end

    assign bus.dut_A     = idx[WIDTH-1:0];
    assign bus.dut_B     = idx[2*WIDTH-1:WIDTH];
    assign bus.dut_Cin   = idx[2*WIDTH];
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.err_count = err_count_q;
    assign bus.max_ed    = max_ed_q;
    assign bus.sum_ed    = sum_ed_q;
    assign bus.vec_count = vec_count_q;
endmodule
